// File: rtl/turbo_block_scheduler.sv
// turbo_block_scheduler: shares one turbo encoder between two block sources.
// Ports: clk/rst, req/len/vld/ck/ckp per source, gnt per source, enc_* bit
// stream, busy, blk_done, active_src. Macro TURBO_SCHED_RR_EN: round-robin.
module turbo_block_scheduler #(
  parameter int K_SHORT  = 1056,
  parameter int K_LONG   = 6144,
  parameter int TAIL_GAP = 4,
  parameter int CW       = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic len0,
  input  logic len1,
  input  logic vld0,
  input  logic vld1,
  input  logic ck0,
  input  logic ck1,
  input  logic ckp0,
  input  logic ckp1,
  output logic gnt0,
  output logic gnt1,
  output logic enc_data_valid,
  output logic enc_ck,
  output logic enc_ckp,
  output logic enc_length,
  output logic busy,
  output logic blk_done,
  output logic active_src
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  localparam int GW = (TAIL_GAP < 2) ? 1 : $clog2(TAIL_GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(TAIL_GAP - 1);
  localparam logic [CW-1:0] LAST_S = CW'(K_SHORT - 1);
  localparam logic [CW-1:0] LAST_L = CW'(K_LONG - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap;
  logic          win;
  logic          acc;
  logic          last;
  logic          tail_end;
  logic          grant;

`ifdef TURBO_SCHED_RR_EN
  logic ptr;
  // On contention the pointer names the source not granted last.
  assign win = (req0 & req1) ? ptr : req1;
`else
  assign win = req1 & ~req0;
`endif

  assign acc      = (gnt0 & vld0) | (gnt1 & vld1);
  assign last     = (cnt == (enc_length ? LAST_L : LAST_S));
  assign tail_end = (state == TAIL) && (gap == GAP_LAST);
  // Arbitration runs in IDLE and on the final tail cycle.
  assign grant    = (req0 | req1) && ((state == IDLE) || tail_end);
  assign blk_done = tail_end;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      gap            <= '0;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      enc_data_valid <= 1'b0;
      enc_ck         <= 1'b0;
      enc_ckp        <= 1'b0;
      enc_length     <= 1'b0;
      active_src     <= 1'b0;
`ifdef TURBO_SCHED_RR_EN
      ptr            <= 1'b0;
`endif
    end else begin
      enc_data_valid <= 1'b0;
      unique case (state)
        IDLE: ;
        XFER: begin
          if (acc) begin
            enc_data_valid <= 1'b1;
            enc_ck         <= gnt1 ? ck1 : ck0;
            enc_ckp        <= gnt1 ? ckp1 : ckp0;
            // Counter parks on K-1 rather than wrapping.
            if (last) begin
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
              gap   <= '0;
              state <= TAIL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        TAIL: begin
          gap <= gap + 1'b1;
          if (tail_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (grant) begin
        state      <= XFER;
        gnt0       <= ~win;
        gnt1       <= win;
        enc_length <= win ? len1 : len0;
        active_src <= win;
        cnt        <= '0;
`ifdef TURBO_SCHED_RR_EN
        ptr        <= ~win;
`endif
      end
    end
  end

endmodule

// File: doc/turbo_block_scheduler.md
# turbo_block_scheduler

Arbiter and sequencer that shares one turbo encoder core between two code-block sources. It grants a whole code block to one source at a time. It forwards that source's systematic bit (`ck`), interleaved bit (`ckp`) and length flag to the encoder with the correct `data_valid` framing. Between blocks it enforces a trellis-termination gap, so the encoder's tail and output FIFOs never see overlapping blocks. It sits directly upstream of the encoder top level.

## Interface
Parameters:
- `K_SHORT`, 1056: block length in bits when the length flag is 0
- `K_LONG`, 6144: block length in bits when the length flag is 1
- `TAIL_GAP`, 4: idle cycles inserted after each block's last bit; must be at least 1
- `CW`, 13: bit-counter width; must hold `K_LONG`

Ports:
- `clk`, in, 1: clock
- `rst`, in, 1: reset, synchronous, active-high
- `req0` / `req1`, in, 1: source has a block pending
- `len0` / `len1`, in, 1: block length flag for the source (1 = `K_LONG`); stable while the source's req is high
- `vld0` / `vld1`, in, 1: source presents a bit this cycle
- `ck0` / `ck1`, in, 1: systematic bit
- `ckp0` / `ckp1`, in, 1: interleaved bit
- `gnt0` / `gnt1`, out, 1: source owns the encoder; held high for the whole block
- `enc_data_valid`, out, 1: bit strobe to the encoder
- `enc_ck`, out, 1: systematic bit to the encoder
- `enc_ckp`, out, 1: interleaved bit to the encoder
- `enc_length`, out, 1: length flag of the current block
- `busy`, out, 1: state is not IDLE
- `blk_done`, out, 1: one-cycle pulse at the end of each block's tail gap
- `active_src`, out, 1: index of the granted or last-granted source

## Operation
- **States:** IDLE, XFER, TAIL.
- **IDLE:**
  - If neither source requests, stay in IDLE.
  - If any `reqN` is high, arbitrate and go to XFER.
  - On entry to XFER: `gntN` is set, `lenN` is latched into `enc_length`, and the counter is cleared.
- **XFER:**
  - A bit is accepted on each cycle where `gntN & vldN` is high.
  - An accepted bit is registered to `enc_ck`/`enc_ckp` with `enc_data_valid=1`.
  - On cycles without an accepted bit, `enc_data_valid=0` and the counter holds.
  - `vld` and `ck` from the non-granted source are ignored.
- **End of XFER:** the edge that accepts bit K (K = `K_LONG` if the latched length is 1, otherwise `K_SHORT`) clears `gnt` and moves to TAIL.
  - The counter compares against K-1 using `CW`-bit unsigned arithmetic.
  - The counter never wraps.
- **TAIL:**
  - `enc_data_valid=0` for exactly `TAIL_GAP` cycles.
  - On the last TAIL cycle, `blk_done` is pulsed and arbitration runs.
  - If a request is pending, go directly to XFER; no IDLE cycle is inserted.
  - Otherwise go to IDLE.
- **Request semantics:**
  - Deasserting `req` during XFER is ignored. The block is not aborted; the scheduler waits for all K bits.
  - A `req` still high when arbitration runs counts as a new block.
  - Sources must drop `req` by the `blk_done` cycle if they have no further block.
- **Arbitration:** the policy is set by the macro in Configuration.
  - If both sources request, the winner is set by priority.
  - If one source requests, that source is granted.
- **`enc_length`:** holds its value until the next grant.
- **`active_src`:** updates at each grant.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, counter is 0, and the round-robin pointer favours source 0.
- **Reset mid-block:** the block is dropped without `blk_done`, and the scheduler returns to IDLE on the next edge.
- **Request to grant:** `reqN` sampled high at edge n sets `gntN=1` after edge n.
- **Bit latency:** a bit accepted at edge m appears on `enc_ck`/`enc_ckp` with `enc_data_valid=1` after edge m, giving 1-cycle latency.
- **Block with no stalls:** `gnt` stays high for K cycles.
- **Back-to-back blocks:** the first bit of the next block can be accepted on the cycle after `blk_done`.
  - The minimum gap between the last `enc_data_valid` of one block and the first of the next is `TAIL_GAP`+1 cycles.
- **`busy`:** is 0 only in IDLE.

## Configuration
- **`TURBO_SCHED_RR_EN` defined:** round-robin arbitration.
  - The pointer toggles to the other source after every grant.
  - On simultaneous requests, the source not granted last wins.
- **`TURBO_SCHED_RR_EN` undefined:** fixed priority; source 0 always wins on simultaneous requests, and the pointer logic is absent.

## Test plan
- **Single short block:** `req0=1`, `len0=0`, `vld0` high continuously → `gnt0` high for 1056 cycles, then 1056 `enc_data_valid` pulses, then 4 idle cycles, `blk_done` pulsed once, and the scheduler returns to IDLE with `busy=0`.
- **Long block with stalls:** `req1=1`, `len1=1`, `vld1` low every 3rd cycle → exactly 6144 accepted bits, data on `enc_ck` matches the source sequence, and `enc_length=1` throughout.
- **Contention with `TURBO_SCHED_RR_EN`:** `req0` and `req1` both high continuously → grants alternate 1,0,1,… after the first grant to 0, with `TAIL_GAP` between blocks and no IDLE cycle.
- **Contention without `TURBO_SCHED_RR_EN`:** same stimulus → every grant goes to source 0.
- **Mid-block behaviour:** `req0` dropped at bit 500 → transfer continues to bit 1056. A separate run asserts `rst` at bit 500 → all outputs are 0 next cycle, no `blk_done`, and a new block then starts cleanly.
- **Non-granted source ignored:** `vld1` toggling while only source 0 is granted → no effect on the `enc_*` outputs.
